// File: rtl/hs_link_pkg.sv
// Shared types and sizing helpers for the hs_link master/FIFO/slave link.
package hs_link_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } m_state_e;

  // One extra pointer bit separates the full and empty states when the address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and no write-to-read fall-through.
module hs_sync_fifo
  import hs_link_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic                    i_rd,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ptr_w(DEPTH)-1:0] o_level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_level;
  logic              r_full;
  logic              r_empty;

  logic              w_wr_en;
  logic              w_rd_en;
  logic [PW-1:0]     w_wr_nxt;
  logic [PW-1:0]     w_rd_nxt;

  // Full blocks the write even when a read frees a slot in the same cycle.
  assign w_wr_en  = i_wr && !r_full;
  assign w_rd_en  = i_rd && !r_empty;
  assign w_wr_nxt = r_wr_ptr + PW'(w_wr_en);
  assign w_rd_nxt = r_rd_ptr + PW'(w_rd_en);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_wr_nxt - w_rd_nxt;
      r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                  (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      r_empty  <= (w_wr_nxt == w_rd_nxt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/hs_link_fifo.sv
// Master sequence generator -> elastic FIFO -> slave retire register.
// Optional HS_LINK_STATS_EN adds tx_cnt/rx_cnt transfer counters.
//
// state | meaning
// IDLE  | nothing offered; waits for valid_in
// SEND  | r_m_data offered to the FIFO, held until accepted
module hs_link_fifo
  import hs_link_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 4
`ifdef HS_LINK_STATS_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    valid_in,
  input  logic                    ready_in,
  output logic [DATA_W-1:0]       result,
  output logic                    result_vld,
  output logic                    full,
  output logic                    empty,
  output logic [ptr_w(DEPTH)-1:0] level
`ifdef HS_LINK_STATS_EN
  ,
  output logic [CNT_W-1:0]        tx_cnt,
  output logic [CNT_W-1:0]        rx_cnt
`endif
);

  m_state_e          r_state;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [DATA_W-1:0] r_seq;
  logic [DATA_W-1:0] r_result;
  logic              r_result_vld;

  logic              w_full;
  logic              w_empty;
  logic              w_m_ready;
  logic              w_fire;
  logic              w_rd;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_seq_inc;

  assign w_m_ready = !w_full;
  assign w_fire    = r_m_valid && w_m_ready;
  assign w_rd      = ready_in && !w_empty;
  assign w_seq_inc = r_seq + DATA_W'(1);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_seq     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_state   <= ST_SEND;
            r_m_valid <= 1'b1;
            r_m_data  <= r_seq;
          end
        end
        ST_SEND: begin
          // Without a fire the offer stays put, even if valid_in has dropped.
          if (w_fire) begin
            r_seq <= w_seq_inc;
            if (valid_in) begin
              r_m_data <= w_seq_inc;
            end else begin
              r_state   <= ST_IDLE;
              r_m_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  hs_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_wr    (w_fire),
    .i_wdata (r_m_data),
    .i_rd    (w_rd),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_result     <= '0;
      r_result_vld <= 1'b0;
    end else begin
      r_result_vld <= w_rd;
      if (w_rd) begin
        r_result <= w_head;
      end
    end
  end

  assign result     = r_result;
  assign result_vld = r_result_vld;
  assign full       = w_full;
  assign empty      = w_empty;

`ifdef HS_LINK_STATS_EN
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_rx_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_fire) r_tx_cnt <= r_tx_cnt + CNT_W'(1);
      if (w_rd)   r_rx_cnt <= r_rx_cnt + CNT_W'(1);
    end
  end

  assign tx_cnt = r_tx_cnt;
  assign rx_cnt = r_rx_cnt;
`endif

endmodule

// File: tb/tb_hs_link_fifo.sv
// Directed scenarios plus random valid/ready traffic against a queue-based link model.
module tb_hs_link_fifo;

  localparam int DATA_W = 3;
  localparam int DEPTH  = 4;

  logic             sys_clk;
  logic             sys_rst;
  logic             valid_in;
  logic             ready_in;
  logic [DATA_W-1:0] result;
  logic             result_vld;
  logic             full;
  logic             empty;
  logic [2:0]       level;
`ifdef HS_LINK_STATS_EN
  logic [7:0]       tx_cnt;
  logic [7:0]       rx_cnt;
`endif

  hs_link_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
`ifdef HS_LINK_STATS_EN
    ,
    .CNT_W  (8)
`endif
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .result     (result),
    .result_vld (result_vld),
    .full       (full),
    .empty      (empty),
    .level      (level)
`ifdef HS_LINK_STATS_EN
    ,
    .tx_cnt     (tx_cnt),
    .rx_cnt     (rx_cnt)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: master holds at most one pending item; FIFO is a plain queue.
  int q[$];
  bit m_pend;
  int m_data;
  int m_seq;
  int m_res;
  bit m_vld;
  int m_tx;
  int m_rx;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit v, input bit r, input bit rst);
    bit fire;
    bit rd;
    if (rst) begin
      q.delete();
      m_pend = 0; m_data = 0; m_seq = 0;
      m_res = 0;  m_vld = 0;  m_tx = 0; m_rx = 0;
      return;
    end
    fire = m_pend && (q.size() < DEPTH);
    rd   = r && (q.size() > 0);
    if (rd) begin
      m_res = q.pop_front();
      m_vld = 1;
      m_rx++;
    end else begin
      m_vld = 0;
    end
    if (fire) begin
      q.push_back(m_data);
      m_tx++;
    end
    if (!m_pend) begin
      if (v) begin
        m_pend = 1;
        m_data = m_seq;
      end
    end else if (fire) begin
      m_seq = (m_seq + 1) % (1 << DATA_W);
      if (v) m_data = m_seq;
      else   m_pend = 0;
    end
  endtask

  task automatic step(input bit v, input bit r, input bit rst);
    valid_in = v;
    ready_in = r;
    sys_rst  = rst;
    @(posedge sys_clk);
    model_edge(v, r, rst);
    #1;
    chk("result",     int'(result),     m_res);
    chk("result_vld", int'(result_vld), int'(m_vld));
    chk("full",       int'(full),       int'(q.size() == DEPTH));
    chk("empty",      int'(empty),      int'(q.size() == 0));
    chk("level",      int'(level),      q.size());
`ifdef HS_LINK_STATS_EN
    chk("tx_cnt",     int'(tx_cnt),     m_tx % 256);
    chk("rx_cnt",     int'(rx_cnt),     m_rx % 256);
`endif
  endtask

  initial begin
    int first;
    int cnt;
    int last;
    int pv;
    int pr;

    valid_in = 0;
    ready_in = 0;
    sys_rst  = 1;

    // 1: streaming from reset, latency and back-to-back results
    step(0, 0, 1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_level", int'(level), 0);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0);
      if (result_vld && first < 0) first = i + 1;
    end
    chk("t1_latency", first, 3);

    // 2: back-pressure fills the FIFO, one read frees one slot
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    chk("t2_full",  int'(full),  1);
    chk("t2_level", int'(level), 4);
    step(1, 1, 0);
    chk("t2_res0",  int'(result), 0);
    chk("t2_nfull", int'(full),   0);
    step(0, 0, 0);
    chk("t2_refill", int'(level), 4);
    last = -1;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0);
      if (result_vld) last = int'(result);
    end
    chk("t2_last", last, 4);

    // 3: simultaneous write and read at level 2
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    chk("t3_pre", int'(level), 2);
    step(1, 1, 0);
    chk("t3_level", int'(level),  2);
    chk("t3_res",   int'(result), 0);

    // 4: full, single valid pulse, late ready -> one extra item then idle
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    cnt = 0;
    last = -1;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0);
      if (result_vld) begin
        cnt++;
        last = int'(result);
      end
    end
    chk("t4_count", cnt,  5);
    chk("t4_last",  last, 4);

    // 5: reset mid-operation discards contents and restarts the sequence
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("t5_pre", int'(level), 3);
    step(1, 1, 1);
    chk("t5_empty", int'(empty),      1);
    chk("t5_vld",   int'(result_vld), 0);
    first = -1;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0);
      if (result_vld && first < 0) first = int'(result);
    end
    chk("t5_first", first, 0);

`ifdef HS_LINK_STATS_EN
    // 6: statistics counters, then wrap at 256
    step(0, 0, 1);
    while (m_tx < 10) step(m_tx < 9, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    chk("t6_tx10", int'(tx_cnt), 10);
    chk("t6_rx10", int'(rx_cnt), 10);
    while (m_tx < 256) step(m_tx < 255, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    chk("t6_txwrap", int'(tx_cnt), 0);
    chk("t6_rxwrap", int'(rx_cnt), 0);
`endif

    // Random traffic with shifting valid/ready densities and rare resets
    step(0, 0, 1);
    for (int blk = 0; blk < 8; blk++) begin
      pv = $urandom_range(20, 100);
      pr = $urandom_range(10, 100);
      for (int i = 0; i < 60; i++) begin
        step(($urandom_range(0, 99) < pv), ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 99) < 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
